// File: rtl/spi_slave_phy.sv
// SPI mode-0 slave front end: pin synchronisers, MOSI deserialiser, MISO
// serialiser and frame control, all running in the system clock domain.
module spi_slave_phy #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_sclk,
    input  logic                  i_cs,
    input  logic                  i_mosi,
    output logic                  o_miso,
    output logic [DATA_WIDTH-1:0] o_rx_data,
    output logic                  o_wr,
    input  logic [DATA_WIDTH-1:0] i_tx_data,
    output logic                  o_oe,
    output logic                  o_frame_start,
    output logic                  o_frame_end,
    output logic                  o_busy
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int FW = $clog2(SYNC_STAGES + 2);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);
    localparam logic [FW-1:0] FLUSHED  = FW'(SYNC_STAGES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_IDLE,
        S_LOAD,
        S_XFER
    } state_t;

    state_t r_state, w_state_next;

    logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_mosi_sync;
    logic                   r_sclk_prev, r_cs_prev;
    logic [FW-1:0]          r_flush_cnt;

    logic [DATA_WIDTH-1:0]  r_rx_shift, r_rx_data, r_tx_shift, r_tx_hold;
    logic [CW-1:0]          r_bit_cnt;
    logic                   r_wr, r_hold_pend;

    logic w_sclk_s, w_cs_s, w_mosi_s;
    logic w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise;
    logic w_ready, w_busy, w_xfer_ok;
    logic w_frame_start, w_frame_end;
    logic [DATA_WIDTH-1:0] w_hold_next;

    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk_s & ~r_sclk_prev;
    assign w_sclk_fall = ~w_sclk_s & r_sclk_prev;
    assign w_cs_fall   = ~w_cs_s & r_cs_prev;
    assign w_cs_rise   = w_cs_s & ~r_cs_prev;
    // Edges are only trusted once the synchroniser and previous-value flops
    // hold real pin values rather than their reset fill.
    assign w_ready     = (r_flush_cnt == FLUSHED);
    assign w_busy      = (r_state == S_LOAD) || (r_state == S_XFER);
    // cs rising in the same cycle as an sclk edge ends the frame; the edge is dropped.
    assign w_xfer_ok   = (r_state == S_XFER) && !w_cs_rise;
    // At exactly 4x oversampling the word-boundary fall can coincide with the
    // cycle tx_hold is being captured, so take the buffer data directly then.
    assign w_hold_next = r_hold_pend ? i_tx_data : r_tx_hold;

    // Pin synchronisers, edge-detect history and post-reset flush counter
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_prev <= 1'b0;
            r_cs_prev   <= 1'b1;
            r_flush_cnt <= '0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_cs};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
            r_sclk_prev <= w_sclk_s;
            r_cs_prev   <= w_cs_s;
            if (!w_ready) r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    // Frame state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    // Next-state decode and frame strobes
    always_comb begin
        w_state_next  = r_state;
        w_frame_start = 1'b0;
        w_frame_end   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_ready) begin
                    if (w_cs_fall) begin
                        w_frame_start = 1'b1;
                        w_state_next  = S_LOAD;
                    end else if (!w_cs_s) begin
                        w_state_next  = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (w_cs_s) w_state_next = S_IDLE;
            end
            S_LOAD: begin
                if (w_cs_rise) begin
                    w_frame_end  = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_XFER;
                end
            end
            S_XFER: begin
                if (w_cs_rise) begin
                    w_frame_end  = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Shift registers, bit counter, word strobe and tx hold register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rx_shift  <= '0;
            r_rx_data   <= '0;
            r_tx_shift  <= '0;
            r_tx_hold   <= '0;
            r_bit_cnt   <= '0;
            r_wr        <= 1'b0;
            r_hold_pend <= 1'b0;
        end else begin
            r_wr        <= 1'b0;
            r_hold_pend <= r_wr;
            if (r_hold_pend) r_tx_hold <= i_tx_data;
            if (r_state == S_LOAD) r_tx_shift <= i_tx_data;
            if (w_frame_end) r_bit_cnt <= '0;
            if (w_xfer_ok && w_sclk_rise) begin
                r_rx_shift <= {r_rx_shift[DATA_WIDTH-2:0], w_mosi_s};
                if (r_bit_cnt == LAST_BIT) begin
                    r_bit_cnt <= '0;
                    r_rx_data <= {r_rx_shift[DATA_WIDTH-2:0], w_mosi_s};
                    r_wr      <= 1'b1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
            end
            if (w_xfer_ok && w_sclk_fall) begin
                if (r_bit_cnt == '0) r_tx_shift <= w_hold_next;
                else                 r_tx_shift <= {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
            end
        end
    end

    assign o_rx_data     = r_rx_data;
    assign o_wr          = r_wr;
    assign o_oe          = w_frame_start | r_wr;
    assign o_frame_start = w_frame_start;
    assign o_frame_end   = w_frame_end;
    assign o_busy        = w_busy;
    assign o_miso        = w_busy & r_tx_shift[DATA_WIDTH-1];

endmodule

// File: tb/tb_spi_slave_phy.sv
// Bench for spi_slave_phy: SPI master driver, buffer model and scoreboards.
module tb_spi_slave_phy;

    logic       clk = 1'b0;
    logic       rst_n, sclk, cs, mosi;
    logic       miso, wr, oe, frame_start, frame_end, busy;
    logic [7:0] rx_data, tx_data;

    int vectors = 0;
    int miscompares = 0;

    // observations gathered by the monitor
    int oe_cnt = 0, fs_cnt = 0, fe_cnt = 0, long_cnt = 0, idle_err = 0;
    logic wr_q = 1'b0, oe_q = 1'b0;
    logic [7:0] wr_obs[$];
    logic       miso_obs[$];

    // scoreboards
    logic [7:0] exp_rx[$];
    logic       exp_miso[$];

    // buffer model
    logic [7:0] buf_words[4] = '{8'hA5, 8'h3C, 8'hC3, 8'h0F};
    int buf_req = 0;
    int buf_base = 0;

    spi_slave_phy #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_sclk(sclk), .i_cs(cs), .i_mosi(mosi),
        .o_miso(miso), .o_rx_data(rx_data), .o_wr(wr), .i_tx_data(tx_data),
        .o_oe(oe), .o_frame_start(frame_start), .o_frame_end(frame_end), .o_busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (oe) begin
            tx_data <= buf_words[(buf_req - buf_base) % 4];
            buf_req <= buf_req + 1;
        end
    end

    always @(negedge clk) begin
        if (oe) oe_cnt++;
        if (frame_start) fs_cnt++;
        if (frame_end) fe_cnt++;
        if ((wr && wr_q) || (oe && oe_q)) long_cnt++;
        if ((wr && !busy) || (!busy && miso) || (oe && !busy && !frame_start)) idle_err++;
        if (wr) wr_obs.push_back(rx_data);
        wr_q = wr;
        oe_q = oe;
    end

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1);
    end

    task automatic cs_low();
        @(negedge clk);
        cs = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (4) @(negedge clk);
        cs = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // mode 0: data set on falling edge, miso sampled just before rising edge
    task automatic send_bits(input logic [7:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            mosi = w[7-i];
            repeat (4) @(negedge clk);
            miso_obs.push_back(miso);
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic push_miso(input logic [7:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) exp_miso.push_back(w[7-i]);
    endtask

    task automatic test_reset();
        int fs0;
        logic [7:0] a;
        repeat (3) @(negedge clk);
        a = {2'b00, miso, wr, oe, frame_start, frame_end, busy};
        vectors++;
        if (a !== 8'h00 || rx_data !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_outputs: got flags=%0h rx=%0h required 0/0", a, rx_data);
        end
        fs0 = fs_cnt;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        vectors++;
        if (fs_cnt - fs0 !== 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_cs_low_start: frame_start=%0d busy=%b required 0/0", fs_cnt - fs0, busy);
        end
        cs = 1'b1;
        repeat (8) @(negedge clk);
        vectors++;
        if (fs_cnt - fs0 !== 0) begin
            miscompares++;
            $display("FAIL reset_cs_rise_start: frame_start=%0d required 0", fs_cnt - fs0);
        end
        buf_base = buf_req;
        cs_low();
        vectors++;
        if (fs_cnt - fs0 !== 1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_first_frame: frame_start=%0d busy=%b required 1/1", fs_cnt - fs0, busy);
        end
        cs_high();
    endtask

    task automatic test_one_byte();
        int oe0, fs0, fe0;
        oe0 = oe_cnt; fs0 = fs_cnt; fe0 = fe_cnt;
        buf_base = buf_req;
        exp_rx.push_back(8'h5A);
        push_miso(8'hA5, 8);
        cs_low();
        send_bits(8'h5A, 8);
        cs_high();
        while (exp_rx.size() > 0) begin
            logic [7:0] e;
            e = exp_rx.pop_front();
            vectors++;
            if (wr_obs.size() == 0) begin
                miscompares++; $display("FAIL one_byte_rx: got no wr required %0h", e);
            end else if (wr_obs[0] !== e) begin
                miscompares++; $display("FAIL one_byte_rx: got %0h required %0h", wr_obs[0], e);
                void'(wr_obs.pop_front());
            end else void'(wr_obs.pop_front());
        end
        while (exp_miso.size() > 0) begin
            logic e;
            e = exp_miso.pop_front();
            vectors++;
            if (miso_obs.size() == 0 || miso_obs[0] !== e) begin
                miscompares++; $display("FAIL one_byte_miso: bit %0d required %b", 8 - exp_miso.size() - 1, e);
            end
            if (miso_obs.size() > 0) void'(miso_obs.pop_front());
        end
        vectors++;
        if (wr_obs.size() !== 0 || oe_cnt - oe0 !== 2 || fs_cnt - fs0 !== 1 || fe_cnt - fe0 !== 1) begin
            miscompares++;
            $display("FAIL one_byte_strobes: extra_wr=%0d oe=%0d fs=%0d fe=%0d required 0/2/1/1",
                     wr_obs.size(), oe_cnt - oe0, fs_cnt - fs0, fe_cnt - fe0);
        end
        wr_obs.delete(); miso_obs.delete();
    endtask

    task automatic test_back_to_back();
        int oe0;
        oe0 = oe_cnt;
        buf_base = buf_req;
        exp_rx.push_back(8'hFF); exp_rx.push_back(8'h00);
        push_miso(8'hA5, 8); push_miso(8'h3C, 8);
        cs_low();
        send_bits(8'hFF, 8);
        send_bits(8'h00, 8);
        cs_high();
        while (exp_rx.size() > 0) begin
            logic [7:0] e;
            e = exp_rx.pop_front();
            vectors++;
            if (wr_obs.size() == 0) begin
                miscompares++; $display("FAIL b2b_rx: got no wr required %0h", e);
            end else begin
                if (wr_obs[0] !== e) begin
                    miscompares++; $display("FAIL b2b_rx: got %0h required %0h", wr_obs[0], e);
                end
                void'(wr_obs.pop_front());
            end
        end
        begin
            logic [15:0] got, want;
            got = '0; want = '0;
            for (int i = 0; i < 16; i++) begin
                want = {want[14:0], (exp_miso.size() > 0) ? exp_miso.pop_front() : 1'b0};
                got  = {got[14:0], (miso_obs.size() > 0) ? miso_obs.pop_front() : 1'bx};
            end
            vectors++;
            if (got !== want) begin
                miscompares++; $display("FAIL b2b_miso: got %0h required %0h", got, want);
            end
        end
        vectors++;
        if (wr_obs.size() !== 0 || oe_cnt - oe0 !== 3) begin
            miscompares++;
            $display("FAIL b2b_strobes: extra_wr=%0d oe=%0d required 0/3", wr_obs.size(), oe_cnt - oe0);
        end
        wr_obs.delete(); miso_obs.delete();
    endtask

    task automatic test_abort();
        int oe0, fe0;
        logic [7:0] got, want;
        oe0 = oe_cnt; fe0 = fe_cnt;
        buf_base = buf_req;
        cs_low();
        send_bits(8'hC7, 5);
        cs_high();
        vectors++;
        if (wr_obs.size() !== 0 || oe_cnt - oe0 !== 1 || fe_cnt - fe0 !== 1) begin
            miscompares++;
            $display("FAIL abort_strobes: wr=%0d oe=%0d fe=%0d required 0/1/1",
                     wr_obs.size(), oe_cnt - oe0, fe_cnt - fe0);
        end
        push_miso(8'hA5, 5);
        got = '0; want = '0;
        for (int i = 0; i < 5; i++) begin
            want = {want[6:0], (exp_miso.size() > 0) ? exp_miso.pop_front() : 1'b0};
            got  = {got[6:0], (miso_obs.size() > 0) ? miso_obs.pop_front() : 1'bx};
        end
        vectors++;
        if (got !== want) begin
            miscompares++; $display("FAIL abort_miso: got %0h required %0h", got, want);
        end
        wr_obs.delete(); miso_obs.delete();
        buf_base = buf_req;
        exp_rx.push_back(8'h81);
        cs_low();
        send_bits(8'h81, 8);
        cs_high();
        vectors++;
        if (wr_obs.size() != 1) begin
            miscompares++; $display("FAIL abort_next_count: got %0d wr required 1", wr_obs.size());
        end
        while (exp_rx.size() > 0) begin
            logic [7:0] e;
            e = exp_rx.pop_front();
            vectors++;
            if (wr_obs.size() == 0 || wr_obs[0] !== e) begin
                miscompares++;
                $display("FAIL abort_next_rx: got %0h required %0h", (wr_obs.size() > 0) ? wr_obs[0] : 8'hxx, e);
            end
            if (wr_obs.size() > 0) void'(wr_obs.pop_front());
        end
        got = '0;
        for (int i = 0; i < 8; i++) got = {got[6:0], (miso_obs.size() > 0) ? miso_obs.pop_front() : 1'bx};
        vectors++;
        if (got !== 8'hA5) begin
            miscompares++; $display("FAIL abort_next_miso: got %0h required a5", got);
        end
        wr_obs.delete(); miso_obs.delete();
    endtask

    task automatic test_reset_midword();
        int fs0;
        logic [2:0] got;
        logic [7:0] flags;
        buf_base = buf_req;
        cs_low();
        send_bits(8'hB0, 3);
        mosi = 1'b1;
        repeat (4) @(negedge clk);
        sclk = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        flags = {2'b00, miso, wr, oe, frame_start, frame_end, busy};
        vectors++;
        if (flags !== 8'h00 || rx_data !== 8'h00) begin
            miscompares++;
            $display("FAIL midword_reset_outputs: got flags=%0h rx=%0h required 0/0", flags, rx_data);
        end
        got = '0;
        for (int i = 0; i < 3; i++) got = {got[1:0], (miso_obs.size() > 0) ? miso_obs.pop_front() : 1'bx};
        vectors++;
        if (got !== 3'b101) begin
            miscompares++; $display("FAIL midword_miso: got %b required 101", got);
        end
        repeat (2) @(negedge clk);
        sclk = 1'b0;
        repeat (4) @(negedge clk);
        fs0 = fs_cnt;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        vectors++;
        if (fs_cnt - fs0 !== 0 || busy !== 1'b0 || wr_obs.size() !== 0) begin
            miscompares++;
            $display("FAIL midword_release: fs=%0d busy=%b wr=%0d required 0/0/0", fs_cnt - fs0, busy, wr_obs.size());
        end
        cs = 1'b1;
        repeat (8) @(negedge clk);
        cs_low();
        vectors++;
        if (fs_cnt - fs0 !== 1) begin
            miscompares++; $display("FAIL midword_restart: fs=%0d required 1", fs_cnt - fs0);
        end
        cs_high();
        wr_obs.delete(); miso_obs.delete();
    endtask

    task automatic test_cs_high_sclk();
        int oe0, fs0, e0;
        oe0 = oe_cnt; fs0 = fs_cnt; e0 = idle_err;
        send_bits(8'hFF, 8);
        for (int i = 0; i < 8; i++) exp_miso.push_back(1'b0);
        while (exp_miso.size() > 0) begin
            logic e;
            e = exp_miso.pop_front();
            vectors++;
            if (miso_obs.size() == 0 || miso_obs[0] !== e) begin
                miscompares++; $display("FAIL cs_high_miso: got %b required %b",
                                        (miso_obs.size() > 0) ? miso_obs[0] : 1'bx, e);
            end
            if (miso_obs.size() > 0) void'(miso_obs.pop_front());
        end
        vectors++;
        if (wr_obs.size() !== 0 || oe_cnt - oe0 !== 0 || fs_cnt - fs0 !== 0 || idle_err - e0 !== 0) begin
            miscompares++;
            $display("FAIL cs_high_activity: wr=%0d oe=%0d fs=%0d idle_err=%0d required 0/0/0/0",
                     wr_obs.size(), oe_cnt - oe0, fs_cnt - fs0, idle_err - e0);
        end
    endtask

    initial begin
        rst_n = 1'b0; cs = 1'b0; sclk = 1'b0; mosi = 1'b0;
        test_reset();
        test_one_byte();
        test_back_to_back();
        test_abort();
        test_reset_midword();
        test_cs_high_sclk();
        vectors++;
        if (long_cnt !== 0 || idle_err !== 0) begin
            miscompares++;
            $display("FAIL strobe_rules: long=%0d idle=%0d required 0/0", long_cnt, idle_err);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_slave_phy.md
Name: spi_slave_phy

Overview:
- Serial front end of the SPI slave processing unit; sits directly upstream of spi_buffer.
- Synchronises external SPI pins (mode 0, MSB first) into the system clock domain.
- Deserialises MOSI into words, each delivered with a one-cycle wr strobe.
- Requests outgoing words with a one-cycle oe strobe and serialises them onto MISO.

Parameters:
DATA_WIDTH, 8, bits per SPI word and width of rx_data/tx_data
SYNC_STAGES, 2, flip-flop stages on sclk/cs/mosi synchronisers (min 2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
sclk  in  1  SPI serial clock from master (async)
cs  in  1  SPI chip select, active-low (async)
mosi  in  1  master-out serial data (async)
miso  out  1  slave-out serial data
rx_data  out  DATA_WIDTH  last complete received word
wr  out  1  one-cycle strobe: rx_data valid, write to buffer
tx_data  in  DATA_WIDTH  next word to transmit, valid 1 cycle after oe
oe  out  1  one-cycle strobe: request next tx word from buffer
frame_start  out  1  one-cycle pulse on accepted cs assertion
frame_end  out  1  one-cycle pulse on cs deassertion of an active frame
busy  out  1  high while a frame is active

Behaviour:
- Reset (rst=0, async): state IDLE, all outputs 0, shift registers 0, bit_cnt 0, synchronisers filled with idle values (sclk=0, cs=1, mosi=0).
- Inputs pass SYNC_STAGES flops. Edges detected from the last synced stage vs. a previous-value flop. Requirement: clk >= 4x sclk.
- States: IDLE, WAIT_IDLE, LOAD, XFER.
- Leaving reset with synced cs=0 -> WAIT_IDLE. Stay until cs=1, then IDLE; no mid-frame start.
- IDLE, synced cs falling edge:
  - frame_start=1 and oe=1 in that cycle.
  - Next cycle (LOAD): tx_shift <= tx_data, busy=1, then XFER.
- XFER, sclk rising edge:
  - rx_shift <= {rx_shift[W-2:0], mosi_s}; bit_cnt++.
  - If bit_cnt was W-1: bit_cnt <= 0; next cycle rx_data <= completed word, wr=1 for exactly 1 cycle, oe=1 same cycle as wr; cycle after that, tx_hold <= tx_data.
- XFER, sclk falling edge:
  - If bit_cnt==0 (word boundary): tx_shift <= tx_hold.
  - Else: tx_shift shifts left by one.
  - The first falling edge of a frame (bit_cnt=1) shifts normally.
- miso = tx_shift[W-1] while busy, else 0. Tri-stating is external.
- Synced cs rising edge in XFER or LOAD:
  - frame_end=1, busy=0, bit_cnt=0, state IDLE.
  - Partial word discarded: no wr and no further oe.
  - An oe issued at a word boundary whose word is never shifted is still valid; the buffer treats it as consumed.
- cs high with sclk toggling: ignored.
- Simultaneous cs rise and sclk edge in the same cycle: cs wins, edge ignored.
- rx_data holds its value between wr strobes. wr/oe never exceed one cycle and never fire in IDLE/WAIT_IDLE.
- Latency: last sampling sclk rise (synced) -> wr high = 1 clk; cs fall (synced) -> oe = 0 clk.

Test Plan:
- Setup: clk 10 ns, sclk 80 ns, W=8, buffer model returns 0xA5 then 0x3C.
- Reset with cs=0 held, then cs pulsed high and low again -> no frame_start until cs high->low; outputs all 0 during reset.
- One-byte frame, master sends 0x5A -> exactly one wr with rx_data=0x5A; miso bits 1,0,1,0,0,1,0,1 (0xA5); oe pulses at frame start and at word end; frame_end one pulse.
- Two-byte frame, master sends 0xFF, 0x00 -> wr twice with 0xFF then 0x00; miso streams 0xA5 then 0x3C without gap; 3 oe pulses total.
- cs deasserted after 5 sclk rises, then a new 1-byte frame 0x81 -> no wr for the aborted frame; frame_end pulse; next frame yields rx_data=0x81 and bit_cnt restarted.
- rst asserted mid-word (bit 3) -> all outputs 0 immediately; after release with cs still low, no activity until cs cycles high->low.
- sclk toggled with cs=1 -> no wr/oe/frame_start; miso=0 throughout.
